divisor_sequencial: RTL

- Multi-cycle restoring divider for the 8-bit RPN calculator datapath.
- Responder on the same start/done handshake the top level uses to launch sequential ALU ops.
- The top pulses start from the 10->11 transition, stalls until done, then latches the result into holding registers feeding ULA_comb.
- Produces quotient, remainder, divide-by-zero error, and a nonzero-remainder flag.

---
 rtl/pkg_ula.sv | 15 +
 rtl/passo_divisao.sv | 25 ++
 rtl/divisor_sequencial.sv | 101 ++++++++++
 3 files changed

// File: rtl/pkg_ula.sv
// Shared constants for the RPN calculator ALU: FSM encoding, datapath width,
// the division opcode and the divide-by-zero quotient.
package pkg_ula;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIM  = 2'b10
  } state_t;

  localparam int         DIV_WIDTH = 8;
  localparam logic [2:0] OP_DIV    = 3'b011;  // same code the resto_led decode keys on
  localparam logic [7:0] Q_DIV0    = 8'hFF;

endpackage

// File: rtl/passo_divisao.sv
// One combinational restoring-division step: shift {rem, quo} left, try to
// subtract the divisor, keep the difference only if it did not go negative.
module passo_divisao #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;
  logic           w_neg;

  // One extra bit holds the shifted-out MSB so the sign of the trial is exact.
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, i_divisor};
  assign w_neg   = w_trial[WIDTH];

  assign o_rem = w_neg ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], ~w_neg};

endmodule

// File: rtl/divisor_sequencial.sv
// Multi-cycle unsigned restoring divider on the start/done handshake; one
// quotient bit per CALC cycle, results held after the single-cycle done.
module divisor_sequencial
  import pkg_ula::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             erro,
  output logic             r_exists
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  passo_divisao #(.WIDTH(WIDTH)) u_passo (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_div),
    .o_rem     (w_rem_next),
    .o_quo     (w_quo_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Q        <= '0;
      R        <= '0;
      erro     <= 1'b0;
      r_exists <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (B != '0) begin
              r_quo   <= A;
              r_div   <= B;
              r_rem   <= '0;
              r_cnt   <= '0;
              busy    <= 1'b1;
              r_state <= CALC;
            end else begin
              // Divide-by-zero skips CALC and reports immediately.
              Q        <= {WIDTH{1'b1}};
              R        <= A;
              erro     <= 1'b1;
              r_exists <= (A != '0);
              done     <= 1'b1;
              r_state  <= FIM;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            Q        <= w_quo_next;
            R        <= w_rem_next;
            erro     <= 1'b0;
            r_exists <= (w_rem_next != '0);
            busy     <= 1'b0;
            done     <= 1'b1;
            r_state  <= FIM;
          end
        end
        FIM: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
